// File: rtl/im_fetch_arbiter.sv
// Arbitrates one instruction RAM port between CPU fetch and a program loader.
// Optional write protection of words >= PROT_BASE is enabled by defining IM_ARB_PROT_EN.
module im_fetch_arbiter #(
  parameter int unsigned    AW           = 5,
  parameter int unsigned    MAX_LD_BURST = 4,
  parameter logic [AW-1:0]  PROT_BASE    = 5'd24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [15:0]   iaddr,
  output logic [15:0]   idata,
  output logic          stall,
  input  logic          cpu_halt,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data,
  output logic          ld_ready,
  output logic          ld_err,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  output logic          ram_we,
  input  logic [15:0]   ram_rdata,
  output logic [15:0]   wr_count
);

  localparam int unsigned BW = $clog2(MAX_LD_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_LD_BURST);

  typedef enum logic [1:0] {G_NONE, G_CPU, G_LD} grant_t;

  grant_t        r_grant_q;
  logic [BW-1:0] r_burst_cnt;
  logic [15:0]   r_idata_q;
  logic [15:0]   r_wr_count;
  logic          r_ld_err;

  logic w_ld_gnt;
  logic w_cpu_gnt;
  logic w_prot;
  logic w_unused;

`ifdef IM_ARB_PROT_EN
  assign w_prot   = (ld_addr >= PROT_BASE);
  assign w_unused = ^{iaddr[15:AW+1], iaddr[0]};
`else
  assign w_prot   = 1'b0;
  assign w_unused = ^{iaddr[15:AW+1], iaddr[0], PROT_BASE};
`endif

  // Grants are gated by reset so an in-flight write is dropped the moment reset asserts.
  always_comb begin
    w_ld_gnt  = reset & ld_valid & (cpu_halt | ~fetch_req | (r_burst_cnt < MAX_B));
    w_cpu_gnt = reset & fetch_req & ~cpu_halt & ~w_ld_gnt;
    ram_addr  = w_ld_gnt ? ld_addr : iaddr[AW:1];
    ram_wdata = ld_data;
    ram_we    = w_ld_gnt & ~w_prot;
    ld_ready  = w_ld_gnt;
    stall     = ~reset | (~w_cpu_gnt & (fetch_req | cpu_halt));
    idata     = w_cpu_gnt ? ram_rdata : r_idata_q;
  end

  assign wr_count = r_wr_count;
  assign ld_err   = r_ld_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant_q   <= G_NONE;
      r_burst_cnt <= '0;
      r_idata_q   <= '0;
      r_wr_count  <= '0;
      r_ld_err    <= 1'b0;
    end else begin
      if (w_ld_gnt)       r_grant_q <= G_LD;
      else if (w_cpu_gnt) r_grant_q <= G_CPU;
      else                r_grant_q <= G_NONE;

      if (!fetch_req || w_cpu_gnt)
        r_burst_cnt <= '0;
      else if (w_ld_gnt && r_burst_cnt != MAX_B)
        r_burst_cnt <= r_burst_cnt + 1'b1;

      if (w_cpu_gnt)
        r_idata_q <= ram_rdata;

      if (w_ld_gnt && !w_prot && r_wr_count != '1)
        r_wr_count <= r_wr_count + 16'd1;

      r_ld_err <= w_ld_gnt & w_prot;
    end
  end

  a_cpu_clears_burst: assert property (@(posedge clock) disable iff (!reset)
    (r_grant_q == G_CPU) |-> (r_burst_cnt == '0));

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Directed bench for im_fetch_arbiter with a behavioural 32-word instruction RAM.
module tb_im_fetch_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req, cpu_halt, ld_valid;
  logic [15:0] iaddr, ld_data;
  logic [4:0]  ld_addr;
  logic [15:0] idata, ram_wdata, ram_rdata, wr_count;
  logic        stall, ld_ready, ld_err, ram_we;
  logic [4:0]  ram_addr;

  logic [15:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  im_fetch_arbiter #(.AW(5), .MAX_LD_BURST(4), .PROT_BASE(5'd24)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .iaddr(iaddr), .idata(idata),
    .stall(stall), .cpu_halt(cpu_halt), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_err(ld_err), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .wr_count(wr_count)
  );

  task automatic test_reset();
    reset = 1'b0; ld_valid = 1'b1; fetch_req = 1'b1; cpu_halt = 1'b0;
    iaddr = 16'h0; ld_addr = 5'd0; ld_data = 16'h1234;
    #2;
    checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL rst_stall got %b exp 1", stall); end
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
    checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
    checks++; if (idata !== 16'h0)     begin errors++; $display("FAIL rst_idata got %h exp 0000", idata); end
    checks++; if (wr_count !== 16'h0)  begin errors++; $display("FAIL rst_wr_count got %0d exp 0", wr_count); end
    checks++; if (ld_err !== 1'b0)     begin errors++; $display("FAIL rst_ld_err got %b exp 0", ld_err); end
    @(negedge clock);
    ld_valid = 1'b0; fetch_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_halted_load();
    logic [15:0] w;
    cpu_halt = 1'b1; fetch_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      ld_valid = 1'b1; ld_addr = 5'(i); ld_data = 16'h1000 + 16'(i) * 16'h0111;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL halt_ld_ready[%0d] got %b exp 1", i, ld_ready); end
      checks++; if (ram_we !== 1'b1)   begin errors++; $display("FAIL halt_ram_we[%0d] got %b exp 1", i, ram_we); end
    end
    @(negedge clock);
    ld_valid = 1'b0;
    #1;
    checks++; if (wr_count !== 16'd9) begin errors++; $display("FAIL halt_wr_count got %0d exp 9", wr_count); end
    cpu_halt = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      fetch_req = 1'b1; iaddr = 16'(2 * i);
      w = 16'h1000 + 16'(i) * 16'h0111;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall[%0d] got %b exp 0", i, stall); end
      checks++; if (idata !== w)    begin errors++; $display("FAIL fetch_idata[%0d] got %h exp %h", i, idata, w); end
    end
  endtask

  task automatic test_starvation();
    logic [15:0] hold;
    hold = 16'h1888;
    @(negedge clock);
    fetch_req = 1'b1; ld_valid = 1'b1; cpu_halt = 1'b0;
    iaddr = 16'h0006; ld_addr = 5'd20; ld_data = 16'h5A5A;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clock);
      #1;
      if ((k % 5) < 4) begin
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL starve_L_ready[%0d] got %b exp 1", k, ld_ready); end
        checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL starve_L_stall[%0d] got %b exp 1", k, stall); end
        checks++; if (idata !== hold)    begin errors++; $display("FAIL starve_L_idata[%0d] got %h exp %h", k, idata, hold); end
      end else begin
        checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL starve_C_ready[%0d] got %b exp 0", k, ld_ready); end
        checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL starve_C_stall[%0d] got %b exp 0", k, stall); end
        checks++; if (idata !== 16'h1333)  begin errors++; $display("FAIL starve_C_idata[%0d] got %h exp 1333", k, idata); end
        hold = 16'h1333;
      end
    end
    @(negedge clock);
    ld_valid = 1'b0; fetch_req = 1'b0;
    #1;
    checks++; if (wr_count !== 16'd17) begin errors++; $display("FAIL starve_wr_count got %0d exp 17", wr_count); end
    checks++; if (idata !== 16'h1333)  begin errors++; $display("FAIL starve_hold_idle got %h exp 1333", idata); end
  endtask

  task automatic test_coherence();
    @(negedge clock);
    fetch_req = 1'b0; ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 16'h8A3C;
    @(negedge clock);
    ld_valid = 1'b0; fetch_req = 1'b1; iaddr = 16'h000E;
    #1;
    checks++; if (idata !== 16'h8A3C)  begin errors++; $display("FAIL coh_idata got %h exp 8a3c", idata); end
    checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL coh_stall got %b exp 0", stall); end
    checks++; if (wr_count !== 16'd18) begin errors++; $display("FAIL coh_wr_count got %0d exp 18", wr_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    fetch_req = 1'b0; ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 16'hDEAD;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got %b exp 1", ram_we); end
    #1 reset = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0)   begin errors++; $display("FAIL mid_we got %b exp 0", ram_we); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", ld_ready); end
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL mid_stall got %b exp 1", stall); end
    @(negedge clock);
    ld_valid = 1'b0; reset = 1'b1;
    #1;
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL mid_wr_count got %0d exp 0", wr_count); end
    @(negedge clock);
    fetch_req = 1'b1; iaddr = 16'h0006;
    #1;
    checks++; if (idata !== 16'h1333) begin errors++; $display("FAIL mid_word3 got %h exp 1333", idata); end
    @(negedge clock);
    fetch_req = 1'b0;
  endtask

  task automatic test_protection();
`ifdef IM_ARB_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    logic [15:0] c0;
    c0 = wr_count;
    @(negedge clock);
    ld_valid = 1'b1; ld_addr = 5'd25; ld_data = 16'hC0DE;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL prot25_ready got %b exp 1", ld_ready); end
    checks++; if (ram_we !== ~PROT)  begin errors++; $display("FAIL prot25_we got %b exp %b", ram_we, ~PROT); end
    checks++; if (ld_err !== 1'b0)   begin errors++; $display("FAIL prot25_err_now got %b exp 0", ld_err); end
    @(negedge clock);
    ld_addr = 5'd23; ld_data = 16'hBEEF;
    #1;
    checks++; if (ld_err !== PROT)  begin errors++; $display("FAIL prot_err_next got %b exp %b", ld_err, PROT); end
    checks++; if (ram_we !== 1'b1)  begin errors++; $display("FAIL prot23_we got %b exp 1", ram_we); end
    @(negedge clock);
    ld_addr = 5'd26; ld_data = 16'h1111;
    #1;
    checks++; if (ld_err !== 1'b0)  begin errors++; $display("FAIL prot23_err got %b exp 0", ld_err); end
    @(negedge clock);
    ld_addr = 5'd27; ld_data = 16'h2222;
    #1;
    checks++; if (ld_err !== PROT)  begin errors++; $display("FAIL prot_b2b_a got %b exp %b", ld_err, PROT); end
    @(negedge clock);
    ld_valid = 1'b0;
    #1;
    checks++; if (ld_err !== PROT)  begin errors++; $display("FAIL prot_b2b_b got %b exp %b", ld_err, PROT); end
    checks++; if (wr_count !== c0 + (PROT ? 16'd1 : 16'd4))
      begin errors++; $display("FAIL prot_wr_count got %0d exp %0d", wr_count, c0 + (PROT ? 16'd1 : 16'd4)); end
    @(negedge clock);
    #1;
    checks++; if (ld_err !== 1'b0)  begin errors++; $display("FAIL prot_err_clear got %b exp 0", ld_err); end
    fetch_req = 1'b1; iaddr = 16'd50;
    #1;
    checks++; if (idata !== (PROT ? 16'h0000 : 16'hC0DE))
      begin errors++; $display("FAIL prot25_word got %h exp %h", idata, PROT ? 16'h0000 : 16'hC0DE); end
    @(negedge clock);
    iaddr = 16'd46;
    #1;
    checks++; if (idata !== 16'hBEEF) begin errors++; $display("FAIL prot23_word got %h exp beef", idata); end
    @(negedge clock);
    fetch_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    test_reset();
    test_halted_load();
    test_starvation();
    test_coherence();
    test_reset_mid();
    test_protection();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
